// File: rtl/bsg_tag_packet_tx.sv
// Serializer for the bsg_tag configuration bus: turns one parallel command into
// either a client packet or a master-reset run of ones, LSB-first.
module bsg_tag_packet_tx #(
    parameter int els_p               = 32,
    parameter int max_payload_width_p = 10,
    parameter int reset_ones_p        = 32,
    parameter int gap_p               = 1,
    localparam int idw_lp = (els_p > 1) ? $clog2(els_p) : 1,
    localparam int lgw_lp = ($clog2(max_payload_width_p + 1) > 0) ? $clog2(max_payload_width_p + 1) : 1
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic                           v_i,
    output logic                           ready_o,
    input  logic                           master_reset_i,
    input  logic [idw_lp-1:0]              node_id_i,
    input  logic                           data_not_reset_i,
    input  logic [lgw_lp-1:0]              len_i,
    input  logic [max_payload_width_p-1:0] payload_i,
    output logic                           tag_data_o,
    output logic                           tag_en_o,
    output logic                           done_o
);

    localparam int pkt_w_lp   = 2 + idw_lp + lgw_lp + max_payload_width_p;
    localparam int cnt_max_lp = (reset_ones_p > pkt_w_lp)
                              ? ((reset_ones_p > gap_p) ? reset_ones_p : gap_p)
                              : ((pkt_w_lp > gap_p) ? pkt_w_lp : gap_p);
    localparam int cnt_w_lp   = $clog2(cnt_max_lp + 1);

    localparam logic [1:0] s_idle  = 2'd0;
    localparam logic [1:0] s_rst   = 2'd1;
    localparam logic [1:0] s_shift = 2'd2;
    localparam logic [1:0] s_gap   = 2'd3;

    localparam logic [lgw_lp-1:0] max_len_lp = lgw_lp'(max_payload_width_p);

    // Handshake: a command transfers on any cycle where v_i and ready_o are both
    // high; ready_o only rises in IDLE, and fields are sampled on that cycle only.

    logic [1:0]          state_r;
    logic [pkt_w_lp-1:0] shift_r;
    logic [cnt_w_lp-1:0] cnt_r;
    logic                tag_data_r;
    logic                tag_en_r;
    logic                done_r;

    logic                accept;
    logic [lgw_lp-1:0]   len_clip;
    logic [pkt_w_lp-1:0] pkt_bits;
    logic [cnt_w_lp-1:0] pkt_last;

    assign ready_o    = (state_r == s_idle) & ~reset_i;
    assign accept     = v_i & ready_o;
    assign tag_data_o = tag_data_r;
    assign tag_en_o   = tag_en_r;
    assign done_o     = done_r;

    always_comb begin
        len_clip = (len_i > max_len_lp) ? max_len_lp : len_i;
        pkt_bits = {payload_i, len_clip, data_not_reset_i, node_id_i, 1'b1};
        // Counter holds the number of bits still to follow the one on the wire.
        pkt_last = cnt_w_lp'(1 + idw_lp + lgw_lp) + cnt_w_lp'(len_clip);
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r    <= s_idle;
            shift_r    <= '0;
            cnt_r      <= '0;
            tag_data_r <= 1'b0;
            tag_en_r   <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                s_idle: begin
                    if (accept) begin
                        tag_en_r <= 1'b1;
                        if (master_reset_i) begin
                            state_r    <= s_rst;
                            tag_data_r <= 1'b1;
                            cnt_r      <= cnt_w_lp'(reset_ones_p - 1);
                        end else begin
                            state_r    <= s_shift;
                            tag_data_r <= pkt_bits[0];
                            shift_r    <= pkt_bits >> 1;
                            cnt_r      <= pkt_last;
                        end
                    end
                end
                s_rst, s_shift: begin
                    if (cnt_r == '0) begin
                        state_r    <= s_gap;
                        tag_data_r <= 1'b0;
                        tag_en_r   <= 1'b0;
                        done_r     <= 1'b1;
                        cnt_r      <= cnt_w_lp'(gap_p - 1);
                    end else begin
                        cnt_r <= cnt_r - 1'b1;
                        if (state_r == s_shift) begin
                            tag_data_r <= shift_r[0];
                            shift_r    <= shift_r >> 1;
                        end
                    end
                end
                s_gap: begin
                    if (cnt_r == '0) state_r <= s_idle;
                    else             cnt_r   <= cnt_r - 1'b1;
                end
                default: state_r <= s_idle;
            endcase
        end
    end

endmodule

// File: tb/tb_bsg_tag_packet_tx.sv
// Bench for bsg_tag_packet_tx: directed cases plus random traffic, with a
// monitor that deframes tag_data_o by tag_en_o and compares against a model.
module tb_bsg_tag_packet_tx;

    localparam int ELS   = 32;
    localparam int MAXP  = 10;
    localparam int RONES = 32;
    localparam int GAP   = 1;
    localparam int IDW   = $clog2(ELS);
    localparam int LGW   = $clog2(MAXP + 1);

    logic            clk_i = 1'b0;
    logic            reset_i = 1'b1;
    logic            v_i = 1'b0;
    logic            ready_o;
    logic            master_reset_i = 1'b0;
    logic [IDW-1:0]  node_id_i = '0;
    logic            data_not_reset_i = 1'b0;
    logic [LGW-1:0]  len_i = '0;
    logic [MAXP-1:0] payload_i = '0;
    logic            tag_data_o;
    logic            tag_en_o;
    logic            done_o;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    logic [31:0] exp_q[$];
    int          exp_len_q[$];
    int          exp_start_q[$];

    bit          in_frame = 0;
    bit          ready_chk = 0;
    logic [31:0] got_bits;
    int          got_n;
    int          got_start;

    bsg_tag_packet_tx #(
        .els_p(ELS), .max_payload_width_p(MAXP), .reset_ones_p(RONES), .gap_p(GAP)
    ) dut (
        .clk_i(clk_i), .reset_i(reset_i), .v_i(v_i), .ready_o(ready_o),
        .master_reset_i(master_reset_i), .node_id_i(node_id_i),
        .data_not_reset_i(data_not_reset_i), .len_i(len_i), .payload_i(payload_i),
        .tag_data_o(tag_data_o), .tag_en_o(tag_en_o), .done_o(done_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference: the wire image is the fields concatenated LSB-first.
    function automatic void expect_cmd(input bit mr, input int node, input bit dnr,
                                       input int len, input int payload, input int start);
        logic [31:0] b;
        int n;
        int l;
        b = '0;
        n = 0;
        if (mr) begin
            for (int i = 0; i < RONES; i++) begin b[n] = 1'b1; n++; end
        end else begin
            l = (len > MAXP) ? MAXP : len;
            b[n] = 1'b1; n++;
            for (int i = 0; i < IDW; i++) begin b[n] = node[i]; n++; end
            b[n] = dnr; n++;
            for (int i = 0; i < LGW; i++) begin b[n] = l[i]; n++; end
            for (int i = 0; i < l; i++) begin b[n] = payload[i]; n++; end
        end
        exp_q.push_back(b);
        exp_len_q.push_back(n);
        exp_start_q.push_back(start);
    endfunction

    always @(negedge clk_i) begin
        if (reset_i) begin
            in_frame  = 0;
            ready_chk = 0;
        end else if (tag_en_o) begin
            if (!in_frame) begin
                in_frame  = 1;
                got_n     = 0;
                got_bits  = '0;
                got_start = cyc;
            end
            if (got_n < 32) got_bits[got_n] = tag_data_o;
            got_n++;
            check("busy_ready", {31'b0, ready_o}, 32'd0);
            check("busy_done", {31'b0, done_o}, 32'd0);
        end else begin
            check("idle_data", {31'b0, tag_data_o}, 32'd0);
            if (in_frame) begin
                in_frame = 0;
                check("done_pulse", {31'b0, done_o}, 32'd1);
                check("gap_ready", {31'b0, ready_o}, 32'd0);
                check("frame_expected", {31'b0, exp_len_q.size() > 0}, 32'd1);
                if (exp_len_q.size() > 0) begin
                    check("frame_len", got_n, exp_len_q.pop_front());
                    check("frame_bits", got_bits, exp_q.pop_front());
                    check("frame_start", got_start, exp_start_q.pop_front());
                end
                ready_chk = 1;
            end else begin
                check("idle_done", {31'b0, done_o}, 32'd0);
                if (ready_chk) begin
                    check("ready_return", {31'b0, ready_o}, 32'd1);
                    ready_chk = 0;
                end
            end
        end
    end

    task automatic scramble();
        master_reset_i   = 1'($urandom);
        node_id_i        = IDW'($urandom);
        data_not_reset_i = 1'($urandom);
        len_i            = LGW'($urandom);
        payload_i        = MAXP'($urandom);
    endtask

    task automatic send(input bit mr, input int node, input bit dnr, input int len,
                        input int payload, input bit hold);
        int budget;
        budget = 0;
        @(negedge clk_i);
        master_reset_i   = mr;
        node_id_i        = node[IDW-1:0];
        data_not_reset_i = dnr;
        len_i            = len[LGW-1:0];
        payload_i        = payload[MAXP-1:0];
        v_i              = 1'b1;
        while (!ready_o && budget < 100) begin
            @(negedge clk_i);
            budget++;
        end
        if (!ready_o) begin
            check("accept_timeout", {31'b0, ready_o}, 32'd1);
            v_i = 1'b0;
            return;
        end
        expect_cmd(mr, node, dnr, len, payload, cyc + 1);
        @(posedge clk_i);
        #1;
        v_i = hold;
        scramble();
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        while ((exp_len_q.size() != 0 || in_frame || !ready_o) && budget < 300) begin
            @(negedge clk_i);
            budget++;
        end
        check("drain_pending", exp_len_q.size(), 32'd0);
        repeat (2) @(negedge clk_i);
    endtask

    initial begin
        #1;
        check("rst_ready", {31'b0, ready_o}, 32'd0);
        check("rst_en", {31'b0, tag_en_o}, 32'd0);
        check("rst_data", {31'b0, tag_data_o}, 32'd0);
        check("rst_done", {31'b0, done_o}, 32'd0);
        repeat (3) @(posedge clk_i);
        #2 reset_i = 1'b0;

        send(0, 3, 1, 2, 'b10, 0);
        drain();
        send(1, 9, 1, 5, 'h155, 0);
        drain();
        send(0, 31, 0, 0, 'h3FF, 0);
        drain();
        send(0, 7, 1, 15, 'h3A5, 0);
        drain();

        send(0, 12, 1, 4, 'h2C9, 1);
        send(0, 20, 0, 7, 'h0F3, 0);
        drain();

        send(0, 5, 1, 3, 'h1B6, 0);
        repeat (3) @(posedge clk_i);
        #2 reset_i = 1'b1;
        #1;
        check("midrst_en", {31'b0, tag_en_o}, 32'd0);
        check("midrst_data", {31'b0, tag_data_o}, 32'd0);
        check("midrst_ready", {31'b0, ready_o}, 32'd0);
        check("midrst_done", {31'b0, done_o}, 32'd0);
        exp_q.delete();
        exp_len_q.delete();
        exp_start_q.delete();
        repeat (2) @(posedge clk_i);
        #2 reset_i = 1'b0;
        send(0, 17, 1, 6, 'h2AB, 0);
        drain();

        for (int k = 0; k < 40; k++) begin
            bit hold;
            hold = ($urandom_range(0, 2) == 0);
            send($urandom_range(0, 7) == 0, $urandom_range(0, ELS - 1), 1'($urandom),
                 $urandom_range(0, 15), $urandom, hold);
            if (!hold) repeat ($urandom_range(0, 3)) @(negedge clk_i);
        end
        @(negedge clk_i);
        v_i = 1'b0;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
